// File: rtl/antitheft_pkg.sv
// Shared state encodings and helpers for the multi-door anti-theft controller.
package antitheft_pkg;

   localparam int STATE_W = 3;

   typedef logic [STATE_W-1:0] state_t;

   localparam logic [STATE_W-1:0] S_OFF_DISARMED = 3'd0;
   localparam logic [STATE_W-1:0] S_ARM_WAIT     = 3'd1;
   localparam logic [STATE_W-1:0] S_OFF_ARMED    = 3'd2;
   localparam logic [STATE_W-1:0] S_ENTRY_WAIT   = 3'd3;
   localparam logic [STATE_W-1:0] S_ALARM        = 3'd4;
   localparam logic [STATE_W-1:0] S_ALARM_HOLD   = 3'd5;
   localparam logic [STATE_W-1:0] S_ON_DISARMED  = 3'd6;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [4:0] lowest_set_idx(input logic [31:0] i_vec);
      logic [4:0] r_idx;
      r_idx = '0;
      for (int i = 31; i >= 0; i--) begin
         if (i_vec[i]) r_idx = 5'(i);
      end
      return r_idx;
   endfunction

endpackage

// File: rtl/antitheft_countdown.sv
// Seconds countdown: load forces a non-zero start, each tick decrements to zero.
module antitheft_countdown
   import antitheft_pkg::*;
#(
   parameter int TIMER_W = 5
) (
   input  logic               clock,
   input  logic               systemReset,
   input  logic               load,
   input  logic               clear,
   input  logic [TIMER_W-1:0] loadValue,
   input  logic               tick,
   output logic [TIMER_W-1:0] count,
   output logic               expired
);

   logic [TIMER_W-1:0] r_count;

   // A zero load would never expire, so it is promoted to one second.
   always_ff @(posedge clock) begin
      if (systemReset) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= (loadValue == '0) ? TIMER_W'(1) : loadValue;
      end else if (clear) begin
         r_count <= '0;
      end else if (tick && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign count   = r_count;
   assign expired = tick && (r_count == TIMER_W'(1));

endmodule

// File: rtl/multi_door_antitheft_fsm.sv
// Multi-door anti-theft controller with integrated seconds countdown and
// programmable arm, entry and siren-hold delays.
module multi_door_antitheft_fsm
   import antitheft_pkg::*;
#(
   parameter int NUM_DOORS         = 4,
   parameter int DRIVER_IDX        = 0,
   parameter int T_ARM             = 6,
   parameter int T_DRIVER_DELAY    = 8,
   parameter int T_PASSENGER_DELAY = 15,
   parameter int T_ALARM_ON        = 10,
   parameter int TIMER_W           = 5
) (
   input  logic                         clock,
   input  logic                         systemReset,
   input  logic                         clock1Hz,
   input  logic                         ignition,
   input  logic [NUM_DOORS-1:0]         doorClosed,
   output logic                         status,
   output logic                         siren,
   output logic [STATE_W-1:0]           stateCode,
   output logic [$clog2(NUM_DOORS)-1:0] triggerDoor,
   output logic [TIMER_W-1:0]           timeLeft
);

   localparam int TD_W = $clog2(NUM_DOORS);

   logic [STATE_W-1:0] r_state;
   logic               r_blink;
   logic               r_doorWasOpen;
   logic [TD_W-1:0]    r_trigger;

   logic [STATE_W-1:0] w_nextState;
   logic               w_nextDoorWasOpen;
   logic [TD_W-1:0]    w_nextTrigger;
   logic               w_load;
   logic               w_clear;
   logic [TIMER_W-1:0] w_loadValue;
   logic [TIMER_W-1:0] w_count;
   logic               w_expired;
   logic               w_anyOpen;
   logic               w_driverOpen;

   assign w_anyOpen    = ~(&doorClosed);
   assign w_driverOpen = ~doorClosed[DRIVER_IDX];

   antitheft_countdown #(
      .TIMER_W (TIMER_W)
   ) u_countdown (
      .clock       (clock),
      .systemReset (systemReset),
      .load        (w_load),
      .clear       (w_clear),
      .loadValue   (w_loadValue),
      .tick        (clock1Hz),
      .count       (w_count),
      .expired     (w_expired)
   );

   // Expiry outranks ignition everywhere except ENTRY_WAIT, where a disarm
   // attempt must win. Leaving a timed state early clears the countdown.
   always_comb begin
      w_nextState       = r_state;
      w_nextDoorWasOpen = r_doorWasOpen;
      w_nextTrigger     = r_trigger;
      w_load            = 1'b0;
      w_clear           = 1'b0;
      w_loadValue       = '0;
      case (r_state)
         S_OFF_DISARMED: begin
            if (ignition) begin
               w_nextState = S_ON_DISARMED;
            end else if (w_anyOpen) begin
               w_nextDoorWasOpen = 1'b1;
            end else if (r_doorWasOpen) begin
               w_nextDoorWasOpen = 1'b0;
               w_load            = 1'b1;
               w_loadValue       = TIMER_W'(T_ARM);
               w_nextState       = S_ARM_WAIT;
            end
         end
         S_ARM_WAIT: begin
            if (w_expired) begin
               w_nextState = S_OFF_ARMED;
            end else if (ignition) begin
               w_nextState = S_ON_DISARMED;
               w_clear     = 1'b1;
            end else if (w_anyOpen) begin
               w_nextState       = S_OFF_DISARMED;
               w_nextDoorWasOpen = 1'b1;
               w_clear           = 1'b1;
            end
         end
         S_OFF_ARMED: begin
            if (ignition) begin
               w_nextState = S_ON_DISARMED;
            end else if (w_anyOpen) begin
               w_nextState = S_ENTRY_WAIT;
               w_load      = 1'b1;
               if (w_driverOpen) begin
                  w_loadValue   = TIMER_W'(T_DRIVER_DELAY);
                  w_nextTrigger = TD_W'(DRIVER_IDX);
               end else begin
                  w_loadValue   = TIMER_W'(T_PASSENGER_DELAY);
                  w_nextTrigger = TD_W'(lowest_set_idx(32'(~doorClosed)));
               end
            end
         end
         S_ENTRY_WAIT: begin
            if (ignition) begin
               w_nextState = S_ON_DISARMED;
               w_clear     = 1'b1;
            end else if (w_expired) begin
               w_nextState = S_ALARM;
            end
         end
         S_ALARM: begin
            if (!w_anyOpen) begin
               w_nextState = S_ALARM_HOLD;
               w_load      = 1'b1;
               w_loadValue = TIMER_W'(T_ALARM_ON);
            end
         end
         S_ALARM_HOLD: begin
            if (w_expired) begin
               w_nextState = S_OFF_ARMED;
            end else if (w_anyOpen) begin
               w_nextState = S_ALARM;
               w_clear     = 1'b1;
            end
         end
         S_ON_DISARMED: begin
            if (!ignition) begin
               w_nextState       = S_OFF_DISARMED;
               w_nextDoorWasOpen = 1'b0;
            end
         end
         default: begin
            w_nextState = S_OFF_ARMED;
            w_clear     = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (systemReset) begin
         r_state       <= S_OFF_ARMED;
         r_blink       <= 1'b0;
         r_doorWasOpen <= 1'b0;
         r_trigger     <= '0;
      end else begin
         r_state       <= w_nextState;
         r_doorWasOpen <= w_nextDoorWasOpen;
         r_trigger     <= w_nextTrigger;
         if (clock1Hz) r_blink <= ~r_blink;
      end
   end

   always_comb begin
      status = 1'b0;
      siren  = 1'b0;
      case (r_state)
         S_ARM_WAIT:   status = 1'b1;
         S_OFF_ARMED:  status = r_blink;
         S_ENTRY_WAIT: status = 1'b1;
         S_ALARM: begin
            status = 1'b1;
            siren  = 1'b1;
         end
         S_ALARM_HOLD: begin
            status = 1'b1;
            siren  = 1'b1;
         end
         default: begin
            status = 1'b0;
            siren  = 1'b0;
         end
      endcase
   end

   assign stateCode   = r_state;
   assign triggerDoor = r_trigger;
   assign timeLeft    = w_count;

endmodule

// File: tb/tb_multi_door_antitheft_fsm.sv
// Bench for multi_door_antitheft_fsm: vector table with queued expectations
// plus hand sequences for reset, blink and reset-during-expiry.
module tb_multi_door_antitheft_fsm;

   logic       clock = 1'b0;
   logic       systemReset;
   logic       clock1Hz;
   logic       ignition;
   logic [3:0] doorClosed;
   logic       status;
   logic       siren;
   logic [2:0] stateCode;
   logic [1:0] triggerDoor;
   logic [4:0] timeLeft;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic       ign;
      logic [3:0] doors;
      int         ticks;
      int         st;
      int         sir;
      int         stat;   // 2 = not checked
      int         trig;
      int         tl;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];

   multi_door_antitheft_fsm #(
      .NUM_DOORS(4), .DRIVER_IDX(0), .T_ARM(6), .T_DRIVER_DELAY(8),
      .T_PASSENGER_DELAY(15), .T_ALARM_ON(10), .TIMER_W(5)
   ) dut (
      .clock       (clock),
      .systemReset (systemReset),
      .clock1Hz    (clock1Hz),
      .ignition    (ignition),
      .doorClosed  (doorClosed),
      .status      (status),
      .siren       (siren),
      .stateCode   (stateCode),
      .triggerDoor (triggerDoor),
      .timeLeft    (timeLeft)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
      end
   endtask

   task automatic cyc(input logic rst, input logic tk);
      @(negedge clock);
      systemReset = rst;
      clock1Hz    = tk;
      @(posedge clock);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) begin
         cyc(1'b0, 1'b1);
         cyc(1'b0, 1'b0);
      end
   endtask

   task automatic add(input logic ign, input logic [3:0] doors, input int nt,
                      input int st, input int sir, input int stat,
                      input int trig, input int tl);
      vec_t v;
      v.ign = ign; v.doors = doors; v.ticks = nt; v.st = st; v.sir = sir;
      v.stat = stat; v.trig = trig; v.tl = tl;
      vecs.push_back(v);
   endtask

   task automatic apply_row(input int idx, input vec_t v);
      vec_t e;
      exp_q.push_back(v);
      @(negedge clock);
      ignition   = v.ign;
      doorClosed = v.doors;
      if (v.ticks == 0) cyc(1'b0, 1'b0);
      else ticks(v.ticks);
      e = exp_q.pop_front();
      chk($sformatf("row%0d.state", idx), int'(stateCode), e.st);
      chk($sformatf("row%0d.siren", idx), int'(siren), e.sir);
      if (e.stat != 2) chk($sformatf("row%0d.status", idx), int'(status), e.stat);
      chk($sformatf("row%0d.trigger", idx), int'(triggerDoor), e.trig);
      chk($sformatf("row%0d.timeLeft", idx), int'(timeLeft), e.tl);
   endtask

   initial begin
      systemReset = 1'b1;
      clock1Hz    = 1'b0;
      ignition    = 1'b0;
      doorClosed  = 4'b1111;

      // Reset state
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      chk("reset.state", int'(stateCode), 2);
      chk("reset.siren", int'(siren), 0);
      chk("reset.status", int'(status), 0);
      chk("reset.timeLeft", int'(timeLeft), 0);
      chk("reset.trigger", int'(triggerDoor), 0);

      // Blink toggles once per tick while armed
      cyc(1'b0, 1'b1);
      chk("blink.tick1", int'(status), 1);
      cyc(1'b0, 1'b0);
      chk("blink.hold1", int'(status), 1);
      cyc(1'b0, 1'b1);
      chk("blink.tick2", int'(status), 0);
      cyc(1'b0, 1'b0);

      //   ign  doors    nt  st sir stat trig tl
      add(1'b0, 4'b1011,  0, 3, 0, 1, 2, 15);
      add(1'b0, 4'b1011, 14, 3, 0, 1, 2,  1);
      add(1'b0, 4'b1011,  1, 4, 1, 1, 2,  0);
      add(1'b1, 4'b1011,  2, 4, 1, 1, 2,  0);
      add(1'b0, 4'b1111,  0, 5, 1, 1, 2, 10);
      add(1'b0, 4'b1111,  5, 5, 1, 1, 2,  5);
      add(1'b0, 4'b1101,  0, 4, 1, 1, 2,  0);
      add(1'b0, 4'b1111,  0, 5, 1, 1, 2, 10);
      add(1'b0, 4'b1111,  9, 5, 1, 1, 2,  1);
      add(1'b0, 4'b1111,  1, 2, 0, 2, 2,  0);
      add(1'b0, 4'b1110,  0, 3, 0, 1, 0,  8);
      add(1'b0, 4'b1110,  3, 3, 0, 1, 0,  5);
      add(1'b1, 4'b1110,  0, 6, 0, 0, 0,  0);
      add(1'b0, 4'b1110,  0, 0, 0, 0, 0,  0);
      add(1'b0, 4'b0111,  0, 0, 0, 0, 0,  0);
      add(1'b0, 4'b1111,  0, 1, 0, 1, 0,  6);
      add(1'b0, 4'b1111,  4, 1, 0, 1, 0,  2);
      add(1'b0, 4'b0111,  0, 0, 0, 0, 0,  0);
      add(1'b0, 4'b1111,  0, 1, 0, 1, 0,  6);
      add(1'b0, 4'b1111,  5, 1, 0, 1, 0,  1);
      add(1'b0, 4'b1111,  1, 2, 0, 2, 0,  0);
      add(1'b0, 4'b1101,  0, 3, 0, 1, 1, 15);
      add(1'b0, 4'b1101, 14, 3, 0, 1, 1,  1);
      add(1'b1, 4'b1101,  1, 6, 0, 0, 1,  0);
      add(1'b0, 4'b1111,  0, 0, 0, 0, 1,  0);
      add(1'b0, 4'b1111,  2, 0, 0, 0, 1,  0);
      add(1'b0, 4'b1010,  0, 0, 0, 0, 1,  0);
      add(1'b0, 4'b1111,  0, 1, 0, 1, 1,  6);
      add(1'b0, 4'b1111,  6, 2, 0, 2, 1,  0);
      add(1'b0, 4'b1010,  0, 3, 0, 1, 0,  8);
      add(1'b0, 4'b0000,  2, 3, 0, 1, 0,  6);
      add(1'b1, 4'b1111,  0, 6, 0, 0, 0,  0);
      add(1'b0, 4'b1111,  0, 0, 0, 0, 0,  0);

      foreach (vecs[i]) apply_row(i, vecs[i]);

      // Reset lands on the same edge the entry countdown would expire
      ignition   = 1'b0;
      doorClosed = 4'b0111;
      cyc(1'b0, 1'b0);
      doorClosed = 4'b1111;
      cyc(1'b0, 1'b0);
      ticks(6);
      chk("rstseq.armed", int'(stateCode), 2);
      doorClosed = 4'b1011;
      cyc(1'b0, 1'b0);
      ticks(14);
      chk("rstseq.entry", int'(stateCode), 3);
      chk("rstseq.last_second", int'(timeLeft), 1);
      doorClosed = 4'b1111;
      cyc(1'b1, 1'b1);
      chk("rstseq.state", int'(stateCode), 2);
      chk("rstseq.siren", int'(siren), 0);
      chk("rstseq.timeLeft", int'(timeLeft), 0);
      chk("rstseq.trigger", int'(triggerDoor), 0);
      chk("rstseq.status", int'(status), 0);
      cyc(1'b0, 1'b0);
      ticks(3);
      chk("rstseq.after_state", int'(stateCode), 2);
      chk("rstseq.after_siren", int'(siren), 0);
      chk("rstseq.after_time", int'(timeLeft), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multi_door_antitheft_fsm.md
Name: multi_door_antitheft_fsm

Overview:
- Parametrised successor of the two-door anti-theft controller. Supports NUM_DOORS door sensors, per-role programmable delays, and an integrated seconds countdown, so no external timer handshake is needed.
- Sits between the debounced sensor inputs (ignition, door switches, 1 Hz tick) and the status LED and siren drivers.
- Reports its current state and the door that triggered the alarm for the display/debug logic.

Parameters:
- NUM_DOORS, 4, number of door sensors (>=2); index DRIVER_IDX is the driver door, all others are passenger doors
- DRIVER_IDX, 0, index of the driver door
- T_ARM, 6, seconds from "all doors closed after exit" to armed
- T_DRIVER_DELAY, 8, seconds of grace after the driver door opens while armed
- T_PASSENGER_DELAY, 15, seconds of grace after a passenger door opens while armed
- T_ALARM_ON, 10, seconds the siren persists after all doors close
- TIMER_W, 5, countdown width; must hold the largest T_* value

Ports:
- clock  in  1  system clock
- systemReset  in  1  synchronous, active-high reset; forces OFF_ARMED
- clock1Hz  in  1  single-cycle tick once per second, synchronous to clock
- ignition  in  1  1 = ignition on
- doorClosed  in  NUM_DOORS  1 = door closed, one bit per door
- status  out  1  status LED
- siren  out  1  siren drive
- stateCode  out  3  current state encoding
- triggerDoor  out  $clog2(NUM_DOORS)  door that caused the last arming-violation entry
- timeLeft  out  TIMER_W  current countdown value; 0 when idle

Behaviour:
- Reset and outputs
  - All state is registered; outputs are registered or decoded from registered state only.
  - On systemReset: state=OFF_ARMED, timer=0, blink=0, triggerDoor=0, siren=0. status follows blink, so status=0 on the cycle after reset.
- Blink: the blink register toggles on each clock1Hz tick (2 s period) and free-runs regardless of state.
- Countdown
  - Loading value V sets timer=max(V,1).
  - On each cycle with clock1Hz=1 and timer!=0, timer decrements.
  - expired is a combinational pulse meaning timer==1 && clock1Hz. The state transitions on that same clock edge, and the timer goes to 0.
- States (encodings in package):
  - OFF_DISARMED=0: status=0, siren=0. Tracks a doorWasOpen flag.
    - ignition → ON_DISARMED.
    - Any door open → doorWasOpen=1, stay.
    - All doors closed && doorWasOpen → load T_ARM, clear doorWasOpen, → ARM_WAIT.
  - ARM_WAIT=1: status=1.
    - ignition → ON_DISARMED.
    - Any door open → OFF_DISARMED, with doorWasOpen=1.
    - expired → OFF_ARMED.
  - OFF_ARMED=2: status=blink.
    - ignition → ON_DISARMED. Ignition has priority over a door opening in the same cycle.
    - Any door open → ENTRY_WAIT. Load T_DRIVER_DELAY if the driver door is open, else T_PASSENGER_DELAY.
    - triggerDoor=DRIVER_IDX if the driver door is open, else the lowest-index open door.
  - ENTRY_WAIT=3: status=1.
    - ignition → ON_DISARMED, timer cleared.
    - expired → ALARM.
    - Additional door openings neither restart nor shorten the countdown.
  - ALARM=4: status=1, siren=1.
    - All doors closed → load T_ALARM_ON, → ALARM_HOLD. Ignition is ignored.
  - ALARM_HOLD=5: status=1, siren=1.
    - Any door open → ALARM, timer cleared.
    - expired → OFF_ARMED.
  - ON_DISARMED=6: status=0, siren=0.
    - ignition low → OFF_DISARMED, doorWasOpen=0.
- Illegal state (e.g. 7): → OFF_ARMED next cycle.
- Priority within a state: systemReset > expired > ignition > door events, except in ENTRY_WAIT, where ignition beats expired. The disarm attempt wins.
- triggerDoor holds its value until the next OFF_ARMED → ENTRY_WAIT transition or reset.
- Reset mid-countdown: the timer clears immediately with no residual expiry.

Decomposition:
- Package antitheft_pkg holds:
  - state enum/localparams with 3-bit encodings 0..6
  - STATE_W=3
  - a function for lowest-set-index priority encoding
- Sub-module antitheft_countdown (load, loadValue, tick → count, expired), parametrised by TIMER_W.

Test Plan:
- Reset → stateCode=2, siren=0. status toggles on every clock1Hz tick (LED period 2 ticks).
- Armed, NUM_DOORS=4, open door 2 → stateCode=3, triggerDoor=2, timeLeft=15. After 15 ticks: stateCode=4, siren=1.
- Armed, open door 0, raise ignition after 3 ticks → stateCode=6, siren=0, timeLeft=0. Ignition and expiry on the same edge → still 6.
- ALARM, close all doors → ALARM_HOLD with timeLeft=10. Reopen door 1 at tick 5 → ALARM. Close again and wait 10 ticks → stateCode=2, siren=0.
- From ON_DISARMED: ignition off, open then close door 3 → ARM_WAIT, timeLeft=6. Reopen at tick 4 → OFF_DISARMED. Close and wait 6 ticks → OFF_ARMED.
- Assert systemReset during ENTRY_WAIT with timeLeft=1 on a tick edge → next state=2, no ALARM entry, siren stays 0.
